// File: rtl/issue_check_pkg.sv
// Shared RV32I decode definitions for the issue-group checker.
package issue_check_pkg;

   localparam int unsigned InstW  = 32;
   localparam int unsigned StateW = 2;
   localparam int unsigned RegW   = 5;

   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpOp     = 7'b0110011;

   // Per-lane decode flags used by the pairwise conflict check.
   typedef struct packed {
      logic wr;
      logic use1;
      logic use2;
      logic ctrl;
      logic st;
      logic ld;
   } dec_t;

endpackage

// File: rtl/issue_decode.sv
// issue_decode: one lane's instruction word -> register/memory/control usage flags.
module issue_decode
   import issue_check_pkg::*;
(
   input  logic [InstW-1:0] inst_i,
   output dec_t             dec_o,
   output logic [RegW-1:0]  rd_o,
   output logic [RegW-1:0]  rs1_o,
   output logic [RegW-1:0]  rs2_o
);

   logic [6:0] opc;

   assign opc   = inst_i[6:0];
   assign rd_o  = inst_i[11:7];
   assign rs1_o = inst_i[19:15];
   assign rs2_o = inst_i[24:20];

   // Opcode decode; unknown opcodes (including an all-zero word) use and write nothing.
   always_comb begin
      dec_o = '0;
      case (opc)
         OpLui, OpAuipc: dec_o.wr = 1'b1;
         OpJal: begin
            dec_o.wr   = 1'b1;
            dec_o.ctrl = 1'b1;
         end
         OpJalr: begin
            dec_o.wr   = 1'b1;
            dec_o.use1 = 1'b1;
            dec_o.ctrl = 1'b1;
         end
         OpBranch: begin
            dec_o.use1 = 1'b1;
            dec_o.use2 = 1'b1;
            dec_o.ctrl = 1'b1;
         end
         OpLoad: begin
            dec_o.wr   = 1'b1;
            dec_o.use1 = 1'b1;
            dec_o.ld   = 1'b1;
         end
         OpStore: begin
            dec_o.use1 = 1'b1;
            dec_o.use2 = 1'b1;
            dec_o.st   = 1'b1;
         end
         OpImm: begin
            dec_o.wr   = 1'b1;
            dec_o.use1 = 1'b1;
         end
         OpOp: begin
            dec_o.wr   = 1'b1;
            dec_o.use1 = 1'b1;
            dec_o.use2 = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/issue_check.sv
// issue_check: forms the largest hazard-free in-order issue group from a fetch bundle,
// holding the unissued tail for the following cycles.
module issue_check
   import issue_check_pkg::*;
#(
   parameter int unsigned WIDTH     = 2,
   parameter int unsigned PC_W      = 13,
   parameter int unsigned MEM_ORDER = 1,
   parameter int unsigned CHECK_WAW = 0
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         stall,
   input  logic                         flush_e,
   input  logic                         flush_d,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             in_slot_valid,
   input  logic [WIDTH*PC_W-1:0]        in_pc,
   input  logic [WIDTH*InstW-1:0]       in_inst,
   input  logic [WIDTH*StateW-1:0]      in_state,
   output logic [WIDTH-1:0]             out_valid,
   output logic [WIDTH*PC_W-1:0]        out_pc,
   output logic [WIDTH*InstW-1:0]       out_inst,
   output logic [WIDTH*StateW-1:0]      out_state,
   output logic [$clog2(WIDTH+1)-1:0]   issue_count,
   output logic [WIDTH-1:0]             branch_lane,
   output logic [$clog2(WIDTH+1)-1:0]   hold_count
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);
   typedef logic [CntW-1:0] cnt_t;

   logic [PC_W-1:0]   hold_pc_q    [WIDTH];
   logic [PC_W-1:0]   hold_pc_d    [WIDTH];
   logic [InstW-1:0]  hold_inst_q  [WIDTH];
   logic [InstW-1:0]  hold_inst_d  [WIDTH];
   logic [StateW-1:0] hold_state_q [WIDTH];
   logic [StateW-1:0] hold_state_d [WIDTH];
   cnt_t              hold_cnt_q, hold_cnt_d;
   logic [WIDTH-1:0]  branch_q, branch_d;

   logic [WIDTH-1:0]  win_valid;
   logic [PC_W-1:0]   win_pc    [WIDTH];
   logic [InstW-1:0]  win_inst  [WIDTH];
   logic [StateW-1:0] win_state [WIDTH];
   dec_t              win_dec   [WIDTH];
   logic [RegW-1:0]   win_rd    [WIDTH];
   logic [RegW-1:0]   win_rs1   [WIDTH];
   logic [RegW-1:0]   win_rs2   [WIDTH];

   logic [WIDTH-1:0]  conflict;
   logic [WIDTH-1:0]  issue;
   cnt_t              issue_cnt;
   cnt_t              win_cnt;
   logic              eff_flush;

   assign eff_flush   = flush_e | (flush_d & ~stall);
   assign in_ready    = eff_flush | (~stall & (hold_cnt_q == '0));
   assign hold_count  = hold_cnt_q;
   assign branch_lane = branch_q;

   // Window source: held entries take priority over a new bundle.
   always_comb begin
      logic run;
      run       = 1'b1;
      win_valid = '0;
      for (int k = 0; k < WIDTH; k++) begin
         win_pc[k]    = '0;
         win_inst[k]  = '0;
         win_state[k] = '0;
      end
      if (hold_cnt_q != '0) begin
         for (int k = 0; k < WIDTH; k++) begin
            win_valid[k] = (k < int'(hold_cnt_q));
            win_pc[k]    = hold_pc_q[k];
            win_inst[k]  = hold_inst_q[k];
            win_state[k] = hold_state_q[k];
         end
      end else if (in_valid) begin
         for (int k = 0; k < WIDTH; k++) begin
            // The first invalid slot terminates the bundle.
            run          = run & in_slot_valid[k];
            win_valid[k] = run;
            win_pc[k]    = in_pc[k*PC_W +: PC_W];
            win_inst[k]  = in_inst[k*InstW +: InstW];
            win_state[k] = in_state[k*StateW +: StateW];
         end
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_dec
      issue_decode u_issue_decode (
         .inst_i (win_inst[g]),
         .dec_o  (win_dec[g]),
         .rd_o   (win_rd[g]),
         .rs1_o  (win_rs1[g]),
         .rs2_o  (win_rs2[g])
      );
   end

   // Pairwise conflict matrix: lane j against every older lane i.
   always_comb begin
      conflict = '0;
      for (int j = 1; j < WIDTH; j++) begin
         for (int i = 0; i < j; i++) begin
            if (win_dec[i].wr && (win_rd[i] != '0) &&
                ((win_dec[j].use1 && (win_rs1[j] == win_rd[i])) ||
                 (win_dec[j].use2 && (win_rs2[j] == win_rd[i])))) begin
               conflict[j] = 1'b1;
            end
            if (win_dec[i].ctrl) begin
               conflict[j] = 1'b1;
            end
            if ((MEM_ORDER != 0) && win_dec[i].st && (win_dec[j].st || win_dec[j].ld)) begin
               conflict[j] = 1'b1;
            end
            if ((CHECK_WAW != 0) && win_dec[i].wr && win_dec[j].wr &&
                (win_rd[i] != '0) && (win_rd[i] == win_rd[j])) begin
               conflict[j] = 1'b1;
            end
         end
      end
   end

   // Issue group is the longest conflict-free valid prefix; lane 0 never conflicts.
   always_comb begin
      logic run;
      run       = 1'b1;
      issue     = '0;
      issue_cnt = '0;
      win_cnt   = '0;
      for (int k = 0; k < WIDTH; k++) begin
         run      = run & win_valid[k] & ~conflict[k];
         issue[k] = run;
         if (run) begin
            issue_cnt = issue_cnt + cnt_t'(1);
         end
         if (win_valid[k]) begin
            win_cnt = win_cnt + cnt_t'(1);
         end
      end
   end

   // Issued lane outputs; a flush suppresses issue and idle lanes read as zero.
   always_comb begin
      out_valid   = eff_flush ? '0 : issue;
      issue_count = eff_flush ? '0 : issue_cnt;
      out_pc      = '0;
      out_inst    = '0;
      out_state   = '0;
      for (int k = 0; k < WIDTH; k++) begin
         if (out_valid[k]) begin
            out_pc[k*PC_W +: PC_W]       = win_pc[k];
            out_inst[k*InstW +: InstW]   = win_inst[k];
            out_state[k*StateW +: StateW] = win_state[k];
         end
      end
   end

   // Next hold state: clear on flush, freeze on stall, else shift the unissued tail down.
   always_comb begin
      logic found;
      found      = 1'b0;
      hold_cnt_d = hold_cnt_q;
      branch_d   = branch_q;
      for (int k = 0; k < WIDTH; k++) begin
         hold_pc_d[k]    = hold_pc_q[k];
         hold_inst_d[k]  = hold_inst_q[k];
         hold_state_d[k] = hold_state_q[k];
      end
      if (eff_flush) begin
         hold_cnt_d = '0;
         branch_d   = '0;
         for (int k = 0; k < WIDTH; k++) begin
            hold_pc_d[k]    = '0;
            hold_inst_d[k]  = '0;
            hold_state_d[k] = '0;
         end
      end else if (!stall) begin
         hold_cnt_d = win_cnt - issue_cnt;
         branch_d   = '0;
         for (int k = 0; k < WIDTH; k++) begin
            hold_pc_d[k]    = '0;
            hold_inst_d[k]  = '0;
            hold_state_d[k] = '0;
            for (int s = 0; s < WIDTH; s++) begin
               if ((s == k + int'(issue_cnt)) && win_valid[s]) begin
                  hold_pc_d[k]    = win_pc[s];
                  hold_inst_d[k]  = win_inst[s];
                  hold_state_d[k] = win_state[s];
               end
            end
            if (issue[k] && win_dec[k].ctrl && !found) begin
               branch_d[k] = 1'b1;
               found       = 1'b1;
            end
         end
      end
   end

   // State registers; asynchronous reset discards any held entries.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         hold_cnt_q <= '0;
         branch_q   <= '0;
         for (int k = 0; k < WIDTH; k++) begin
            hold_pc_q[k]    <= '0;
            hold_inst_q[k]  <= '0;
            hold_state_q[k] <= '0;
         end
      end else begin
         hold_cnt_q <= hold_cnt_d;
         branch_q   <= branch_d;
         for (int k = 0; k < WIDTH; k++) begin
            hold_pc_q[k]    <= hold_pc_d[k];
            hold_inst_q[k]  <= hold_inst_d[k];
            hold_state_q[k] <= hold_state_d[k];
         end
      end
   end

endmodule

// File: doc/issue_check.md
ISSUE_CHECK -- requirements
Module: issue_check

Interface
REQ-001 Parameter WIDTH, default 2, number of issue lanes (legal 2..4).
REQ-002 Parameter PC_W, default 13, PC field width.
REQ-003 Parameter MEM_ORDER, default 1: 1 serialises store->store and store->load within a group; 0 disables both checks.
REQ-004 Parameter CHECK_WAW, default 0: 1 also splits a group on equal nonzero rd between two register-writing lanes.
REQ-005 Ports: one clock; reset is asynchronous and active-high.
REQ-006 CLK  in  1  clock, all state on rising edge.
REQ-007 RST  in  1  asynchronous active-high reset.
REQ-008 stall  in  1  downstream stall; freezes all state.
REQ-009 flush_e  in  1  E-stage mispredict; unconditional flush.
REQ-010 flush_d  in  1  D-stage mispredict; flushes only when stall=0.
REQ-011 in_valid  in  1  fetch bundle present.
REQ-012 in_ready  out  1  bundle accepted this cycle.
REQ-013 in_slot_valid  in  WIDTH  per-lane valid, lane 0 oldest; first 0 ends the bundle.
REQ-014 in_pc / in_inst / in_state  in  WIDTH*PC_W / WIDTH*32 / WIDTH*2  packed lane fields, lane i at [i*w +: w].
REQ-015 out_valid  out  WIDTH  lanes issued this cycle, always a prefix (1..1 then 0..0).
REQ-016 out_pc / out_inst / out_state  out  packed as inputs  issued lane fields; zero on lanes with out_valid=0.
REQ-017 issue_count  out  $clog2(WIDTH+1)  popcount of out_valid.
REQ-018 branch_lane  out  WIDTH  registered one-hot of oldest issued control-transfer lane, 0 if none.
REQ-019 hold_count  out  $clog2(WIDTH+1)  entries held back from a previous bundle.

Function
REQ-020 Window = holding buffer when hold_count>0, else incoming bundle when in_valid=1, else empty.
REQ-021 Decode per RV32I opcode[6:0]: writes rd = LUI, AUIPC, JAL, JALR, OP, OP-IMM, LOAD; uses rs1 = JALR, BRANCH, LOAD, STORE, OP-IMM, OP; uses rs2 = BRANCH, STORE, OP; control = BRANCH, JAL, JALR; store = 0100011; load = 0000011.
REQ-022 Lane j (j>0) conflicts with earlier lane i in the window if: i writes rd!=0 and j uses rs1/rs2 equal to it; or i is control; or MEM_ORDER and i store and j store/load; or CHECK_WAW and both write the same rd!=0.
REQ-023 Issue group = longest valid prefix in which no lane conflicts with any earlier lane; lane 0 always issues if valid (forward progress).
REQ-024 Issue is combinational: out_* reflect the window in the same cycle, zero latency.
REQ-025 in_ready = ~stall & (hold_count==0), or 1 during an effective flush.
REQ-026 On a non-stall edge, unissued valid window entries are shifted to lanes 0.. of the holding buffer and hold_count set to their number; else hold_count becomes 0.
REQ-027 branch_lane loads the one-hot of the first control lane within the issued group on each non-stall edge, 0 if none.
REQ-028 stall=1: holding buffer, hold_count, branch_lane unchanged; out_* still driven from window.
REQ-029 Effective flush = flush_e | (flush_d & ~stall): out_valid forced 0, incoming bundle consumed and discarded, next edge clears holding buffer, hold_count, branch_lane.
REQ-030 flush_e with stall=1 still flushes; flush_d with stall=1 is ignored.
REQ-031 Instruction word 0 in a valid lane is a legal no-op that writes nothing, uses nothing.

Reset
REQ-032 RST=1 asynchronously clears holding buffer contents, hold_count=0, branch_lane=0; out_valid=0 and issue_count=0 follow; in_ready=~stall.
REQ-033 Reset mid-hold discards held entries; no entry issues after reset release.

Structure
REQ-034 Shared package holds RV32I opcode constants, the decode-flags struct (wr, use1, use2, ctrl, st, ld) and lane field widths.
REQ-035 One sub-module, issue_decode, per lane: instruction -> decode flags; the pairwise conflict matrix stays in issue_check.

Verification
REQ-036 WIDTH=2: bundle {addi x5,x0,1 ; add x6,x5,x5} -> cycle 1 out_valid=01, hold_count=1 next; cycle 2 add issues on lane 0, in_ready=0 then 1.
REQ-037 WIDTH=4: four independent addi x1..x4 -> out_valid=1111, issue_count=4, hold_count stays 0.
REQ-038 WIDTH=4: {addi ; beq ; addi ; addi} -> out_valid=0011, branch_lane=0010 after edge, hold_count=2.
REQ-039 MEM_ORDER=1 {sw ; lw} -> out_valid=01; MEM_ORDER=0 same bundle -> out_valid=11.
REQ-040 hold_count=2 with stall=1 for 3 cycles then flush_d=1, stall=0 -> hold state frozen during stall, out_valid=0 on flush cycle, hold_count=0 after edge.
REQ-041 RST asserted between edges while hold_count=1 -> hold_count=0 and branch_lane=0 immediately, without a clock edge.
